// File: rtl/timer_counter.sv
// Programmable down-counting timer with bus-mapped CTRL/PRESET/COUNT and a maskable interrupt.
// Define TIMER_AUTO_RELOAD_EN to support auto-reload mode (CTRL.Mode=01).
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

`ifdef TIMER_AUTO_RELOAD_EN
    localparam logic [3:0] CtrlMask = 4'b1111;
`else
    // Mode bits never store a 1 and read back as 0.
    localparam logic [3:0] CtrlMask = 4'b1001;
`endif

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        enable;
    logic        im;
    logic        auto_reload;

    assign enable = ctrl_q[0];
    assign im     = ctrl_q[3];

`ifdef TIMER_AUTO_RELOAD_EN
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
`else
    assign auto_reload = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StLoad;
            end
            StLoad: begin
                count_d = preset_q;
                flag_d  = 1'b0;
                state_d = StCnt;
            end
            StCnt: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (count_q == 32'd0) begin
                    state_d = StInt;
                    flag_d  = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            StInt: begin
                if (auto_reload) begin
                    // Drop the flag on leaving INT so the reload pulse is one cycle wide.
                    state_d = StLoad;
                    flag_d  = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bus writes override the hardware Enable clear and the flag update.
        if (we) begin
            case (addr)
                2'd0: begin
                    ctrl_d = din[3:0] & CtrlMask;
                    flag_d = 1'b0;
                end
                2'd1:    preset_d = din;
                default: ;
            endcase
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout = {28'd0, ctrl_q};
            2'd1:    dout = preset_q;
            2'd2:    dout = count_q;
            default: dout = 32'd0;
        endcase
    end

    assign irq = flag_q & im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus random bus traffic,
// all compared against a behavioural timer model.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;

`ifdef TIMER_AUTO_RELOAD_EN
    localparam logic [3:0] MCtrlMask = 4'hF;
    localparam bit         MHasReload = 1'b1;
`else
    localparam logic [3:0] MCtrlMask = 4'h9;
    localparam bit         MHasReload = 1'b0;
`endif

    // Behavioural model: phase 0 idle, 1 loading, 2 counting, 3 expired.
    int          m_phase;
    logic [3:0]  m_ctrl;
    int unsigned m_preset;
    int unsigned m_count;
    bit          m_flag;

    function automatic void model_reset();
        m_phase  = 0;
        m_ctrl   = 4'd0;
        m_preset = 0;
        m_count  = 0;
        m_flag   = 1'b0;
    endfunction

    function automatic void model_step(input logic w, input logic [1:0] a, input logic [31:0] d);
        int          ph  = m_phase;
        logic [3:0]  c   = m_ctrl;
        int unsigned cnt = m_count;
        bit          f   = m_flag;
        bit          en  = m_ctrl[0];
        bit          rl  = MHasReload && (m_ctrl[2:1] == 2'b01);
        if (m_phase == 0) begin
            if (en) ph = 1;
        end else if (m_phase == 1) begin
            cnt = m_preset;
            f   = 1'b0;
            ph  = 2;
        end else if (m_phase == 2) begin
            if (!en) ph = 0;
            else if (m_count == 0) begin
                ph = 3;
                f  = 1'b1;
            end else cnt = m_count - 1;
        end else begin
            if (rl) begin
                ph = 1;
                f  = 1'b0;
            end else begin
                c[0] = 1'b0;
                ph   = 0;
            end
        end
        if (w && a == 2'd0) begin
            c = d[3:0] & MCtrlMask;
            f = 1'b0;
        end
        if (w && a == 2'd1) m_preset = d;
        m_phase = ph;
        m_ctrl  = c;
        m_count = cnt;
        m_flag  = f;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        we = 1'b0;
        chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
        for (int i = 0; i < 4; i++) begin
            logic [1:0] a = 2'(i);
            addr = a;
            #1;
            chk($sformatf("dout[%0d]", i), dout, model_read(a));
        end
    endtask

    task automatic tick(input logic w, input logic [1:0] a, input logic [31:0] d);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        model_step(w, a, d);
        #1;
        check_all();
    endtask

    task automatic idle_tick();
        tick(1'b0, 2'd0, 32'd0);
    endtask

    // Asserted mid-cycle so the checks land before any clock edge.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_tick();

        // One-shot: PRESET=5, CTRL=0x9 -> irq from the 8th edge on.
        tick(1'b1, 2'd1, 32'd5);
        tick(1'b1, 2'd0, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            idle_tick();
            chk($sformatf("oneshot_irq_k%0d", k), {31'd0, irq}, (k >= 8) ? 32'd1 : 32'd0);
        end
        addr = 2'd0; #1; chk("oneshot_ctrl", dout, 32'h8);
        addr = 2'd2; #1; chk("oneshot_count", dout, 32'd0);

        // PRESET=0 -> irq at the 3rd edge.
        tick(1'b1, 2'd1, 32'd0);
        tick(1'b1, 2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            idle_tick();
            chk($sformatf("zero_irq_k%0d", k), {31'd0, irq}, (k >= 3) ? 32'd1 : 32'd0);
        end

        // Auto-reload: one-cycle pulse every 6 cycles.
        tick(1'b1, 2'd1, 32'd3);
        tick(1'b1, 2'd0, 32'hB);
`ifdef TIMER_AUTO_RELOAD_EN
        for (int k = 1; k <= 20; k++) begin
            idle_tick();
            chk($sformatf("reload_irq_k%0d", k), {31'd0, irq},
                (k >= 6 && (k - 6) % 6 == 0) ? 32'd1 : 32'd0);
        end
`else
        addr = 2'd0; #1; chk("ctrl_mode_masked", dout, 32'h9);
        for (int k = 1; k <= 10; k++) idle_tick();
`endif
        tick(1'b1, 2'd0, 32'h0);

        // Stop mid-count: write lands on the edge that brings COUNT to 4.
        tick(1'b1, 2'd1, 32'd10);
        tick(1'b1, 2'd0, 32'h9);
        for (int i = 0; i < 40 && m_count != 5; i++) idle_tick();
        chk("stop_reached5", m_count, 32'd5);
        tick(1'b1, 2'd0, 32'h8);
        for (int k = 0; k < 4; k++) idle_tick();
        addr = 2'd2; #1; chk("stop_count_hold", dout, 32'd4);
        chk("stop_irq", {31'd0, irq}, 32'd0);

        // Expiry with IM=0, then IM set by a CTRL write that also clears the flag.
        tick(1'b1, 2'd1, 32'd2);
        tick(1'b1, 2'd0, 32'h1);
        for (int k = 0; k < 8; k++) idle_tick();
        chk("masked_irq", {31'd0, irq}, 32'd0);
        tick(1'b1, 2'd0, 32'h8);
        idle_tick();
        chk("masked_unmask_irq", {31'd0, irq}, 32'd0);

        // Reset mid-count with a large preset.
        tick(1'b1, 2'd1, 32'd100);
        tick(1'b1, 2'd0, 32'h9);
        for (int k = 0; k < 5; k++) idle_tick();
        async_reset();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        for (int k = 0; k < 3; k++) idle_tick();
        addr = 2'd2; #1; chk("rst_idle_count", dout, 32'd0);

        // Random bus traffic against the model.
        for (int it = 0; it < 800; it++) begin
            int unsigned r = $urandom_range(0, 99);
            logic [31:0] d = $urandom;
            if (r < 6) begin
                d[0] = ($urandom_range(0, 3) != 0);
                tick(1'b1, 2'd0, d);
            end else if (r < 12) begin
                tick(1'b1, 2'd1, 32'($urandom_range(0, 12)));
            end else if (r < 15) begin
                tick(1'b1, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd2, d);
            end else if (r == 15) begin
                async_reset();
            end else begin
                tick(1'b0, 2'($urandom_range(0, 3)), d);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
